// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC injection path.
// Holds the word width, flit-width helpers and the serializer state encoding.
package noc_pkg;

  localparam int WORD_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic bit flit_w_legal(int w);
    return (w == 8) || (w == 16) ||
           (w == 32) || (w == 64);
  endfunction

  function automatic int num_flits(int w);
    return WORD_W / w;
  endfunction

endpackage

// File: rtl/noc_flit_serializer.sv
// Pops 64-bit words from the injection FIFO and sends them LSB-first
// as NUM_FLITS link flits with head/tail marks and a sent-word counter.
module noc_flit_serializer
  import noc_pkg::*;
#(
  parameter int FLIT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [WORD_W-1:0] fifo_data_out,
  output logic              fifo_read_en,
  output logic              link_valid,
  input  logic              link_ready,
  output logic [FLIT_W-1:0] link_flit,
  output logic              link_head,
  output logic              link_tail,
  output logic              busy,
  output logic [15:0]       word_count
);

  localparam int NUM_FLITS = num_flits(FLIT_W);
  localparam int CNT_W =
    (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_FLITS - 1);

  if (!flit_w_legal(FLIT_W)) begin : g_bad_w
    $error("FLIT_W must be 8, 16, 32 or 64");
  end

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       wc_q, wc_d;
  logic              live_q;

  logic sending;
  logic head;
  logic tail;
  logic fire;
  logic accept;

  assign sending = (state_q == SEND);
  assign head    = sending && (cnt_q == '0);
  assign tail    = sending && (cnt_q == LAST);
  assign fire    = sending && link_ready;

  // live_q keeps the pop strobe low for the first cycle after reset
  assign accept  = live_q &&
                   ((state_q == IDLE) || (fire && tail));

  assign fifo_read_en = accept && !fifo_empty;

  assign link_valid = sending;
  assign link_flit  = sending ? sr_q[FLIT_W-1:0] : '0;
  assign link_head  = head;
  assign link_tail  = tail;
  assign busy       = sending;
  assign word_count = wc_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    wc_d    = wc_q;

    if (fire) begin
      if (tail) begin
        wc_d    = wc_q + 16'd1;
        state_d = IDLE;
      end else begin
        sr_d  = sr_q >> FLIT_W;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (fifo_read_en) begin
      sr_d    = fifo_data_out;
      cnt_d   = '0;
      state_d = SEND;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      wc_q    <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      wc_q    <= wc_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: doc/noc_flit_serializer.md
Name: noc_flit_serializer

Overview:
- Downstream consumer of the 32x64 general-purpose FIFO on the NoC injection path.
- Pops 64-bit words from the FIFO and serializes each into NUM_FLITS link flits of FLIT_W bits on a valid/ready link towards the router input port.
- Marks head and tail flits. Keeps a running count of words sent.
- Never issues an illegal pop, so the FIFO error flag stays low.

Parameters:
- FLIT_W, 16, link flit width in bits. Legal values are 8, 16, 32 and 64.
- NUM_FLITS, derived localparam 64/FLIT_W, number of flits per word. Not overridable.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- fifo_empty  in  1  FIFO empty flag
- fifo_data_out  in  64  FIFO head word; valid whenever fifo_empty=0
- fifo_read_en  out  1  pop strobe to the FIFO, combinational
- link_valid  out  1  flit valid towards the router
- link_ready  in  1  router accepts the flit
- link_flit  out  FLIT_W  current flit
- link_head  out  1  current flit is flit 0 of a word
- link_tail  out  1  current flit is flit NUM_FLITS-1 of a word
- busy  out  1  serializer holds an unsent or partly sent word
- word_count  out  16  words fully sent; wraps modulo 2^16

Behaviour:
- Reset: state=IDLE, shift register=0, flit counter=0, word_count=0. All outputs are 0 while reset is high and in the first cycle after release.
- States: IDLE and SEND.
- Accept condition: accept = (state==IDLE) or (state==SEND and link_valid and link_ready and link_tail).
- Pop rule: fifo_read_en = accept and not fifo_empty. It is never asserted while fifo_empty=1.
- Load: on a clock edge with fifo_read_en=1:
  - capture fifo_data_out into the 64-bit shift register;
  - clear the flit counter;
  - next state is SEND.
  - The FIFO pops on the same edge.
- Latency: fifo_empty falls in cycle T, so fifo_read_en=1 in cycle T and the first flit has link_valid=1 in cycle T+1.
- In SEND:
  - link_valid=1.
  - link_flit = shift register bits [FLIT_W-1:0]. Words go out LSB-first.
  - link_head = (counter==0).
  - link_tail = (counter==NUM_FLITS-1).
- Accepted flit (valid and ready, not tail): shift register shifts right by FLIT_W with zero fill; counter increments.
- Stall (valid and not ready): link_flit, link_head and link_tail hold stable. link_valid never drops before the flit is accepted.
- Tail accepted:
  - word_count increments by 1, wrapping 0xFFFF to 0x0000.
  - If fifo_empty=0 in that cycle, a new word loads in the same cycle and SEND continues with no bubble.
  - Otherwise the next state is IDLE.
- Throughput: with link_ready held at 1 and the FIFO non-empty, one flit per cycle and one word per NUM_FLITS cycles.
- FLIT_W=64: a single flit carries both head=1 and tail=1.
- In IDLE: link_valid, link_head, link_tail and link_flit are all 0.
- busy = (state==SEND).
- Reset mid-word: a word already popped from the FIFO is dropped and state returns to IDLE. Upstream owns any recovery.
- link_ready is ignored in IDLE.

Decomposition:
- Shared package noc_pkg:
  - WORD_W=64
  - legal FLIT_W values and the NUM_FLITS derivation function
  - state enum {IDLE, SEND}
- No sub-module. Optional integration wrapper noc_inject_port instantiating the gp FIFO and this serializer, for system tests only.

Test Plan:
1. Single word, FLIT_W=16, link_ready=1: FIFO holds 0x1122334455667788.
   - Expect exactly one fifo_read_en pulse.
   - Flits 0x7788 (head), 0x5566, 0x3344, 0x1122 (tail) on 4 consecutive cycles starting one cycle after the pop.
   - word_count=1, then IDLE with busy=0.
2. Backpressure: same word, link_ready low for 3 cycles while flit 0x5566 is presented.
   - Flit, head and tail stay stable; link_valid stays 1; no extra pop.
   - Total 7 valid cycles.
3. Back-to-back: FIFO preloaded with 3 words, ready=1.
   - 12 contiguous valid cycles; pops occur in the tail cycles with no bubble.
   - word_count=3; FIFO error never asserts.
4. Empty FIFO for 20 cycles: fifo_read_en=0 and link_valid=0 throughout.
5. Reset asserted during flit 2 of a word:
   - All outputs 0 asynchronously; word_count=0.
   - After release the next FIFO word is serialized from its head flit.
6. Parameter sweep FLIT_W=64 and FLIT_W=8:
   - 64: one flit per word with head=tail=1.
   - 8: 8 flits per word.
   - With 65536 words sent, word_count wraps to 0.
